// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp-vector bit positions and phase-duration lookup
// for the intersection phase sequencer.
package traffic_pkg;

  typedef enum logic [3:0] {
    ST_INIT  = 4'd0,
    ST_MG    = 4'd1,
    ST_MY    = 4'd2,
    ST_AR1   = 4'd3,
    ST_SG    = 4'd4,
    ST_SY    = 4'd5,
    ST_AR2   = 4'd6,
    ST_PED   = 4'd7,
    ST_FLASH = 4'd8
  } state_e;

  localparam int LAMP_W      = 7;
  localparam int LAMP_WALK   = 0;
  localparam int LAMP_SIDE_G = 1;
  localparam int LAMP_SIDE_Y = 2;
  localparam int LAMP_SIDE_R = 3;
  localparam int LAMP_MAIN_G = 4;
  localparam int LAMP_MAIN_Y = 5;
  localparam int LAMP_MAIN_R = 6;

  typedef struct packed {
    logic [15:0] main_g;
    logic [15:0] main_y;
    logic [15:0] side_g;
    logic [15:0] side_y;
    logic [15:0] all_red;
    logic [15:0] ped_walk;
  } dur_cfg_t;

  // The counter runs N..0 inclusive, so it is loaded with duration-1.
  function automatic logic [15:0] dur_m1(input state_e s, input dur_cfg_t cfg);
    logic [15:0] d;
    d = cfg.main_g;
    case (s)
      ST_MY:          d = cfg.main_y;
      ST_AR1, ST_AR2: d = cfg.all_red;
      ST_SG:          d = cfg.side_g;
      ST_SY:          d = cfg.side_y;
      ST_PED:         d = cfg.ped_walk;
      default:        d = cfg.main_g;
    endcase
    return d - 16'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk; no backpressure.
module sync_2ff
  import traffic_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/light_phase_ctrl.sv
// Intersection phase sequencer (main/side/pedestrian/night-flash) closing the loop with the phase counter.
// Lamps decode from registered state; ctr_load/load_count are combinational; no backpressure.
module light_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int pMainGreen   = 15,
  parameter int pMainYellow  = 3,
  parameter int pSideGreen   = 10,
  parameter int pSideYellow  = 3,
  parameter int pAllRed      = 2,
  parameter int pPedWalk     = 8,
  parameter int pCount_width = 5
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    sec_tick,
  input  logic                    light_tick,
  input  logic                    flash_mode,
  input  logic                    ped_req,
  output logic                    ctr_load,
  output logic [pCount_width-1:0] load_count,
  output logic                    main_r,
  output logic                    main_y,
  output logic                    main_g,
  output logic                    side_r,
  output logic                    side_y,
  output logic                    side_g,
  output logic                    walk,
  output logic [3:0]              phase
);

  localparam dur_cfg_t CFG = '{
    main_g:   16'(pMainGreen),
    main_y:   16'(pMainYellow),
    side_g:   16'(pSideGreen),
    side_y:   16'(pSideYellow),
    all_red:  16'(pAllRed),
    ped_walk: 16'(pPedWalk)
  };

  logic              flash_s;
  logic              ped_s;
  state_e            state_q;
  state_e            state_d;
  logic              ped_pending;
  logic              flash_tgl;
  logic [LAMP_W-1:0] lamps;

  sync_2ff u_sync_flash (.clk(clk), .rstb(rstb), .d(flash_mode), .q(flash_s));
  sync_2ff u_sync_ped   (.clk(clk), .rstb(rstb), .d(ped_req),    .q(ped_s));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Flash is only honoured at AR2/PED expiry so it never truncates a green or yellow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (sec_tick)   state_d = ST_MG;
      ST_MG:    if (light_tick) state_d = ST_MY;
      ST_MY:    if (light_tick) state_d = ST_AR1;
      ST_AR1:   if (light_tick) state_d = ST_SG;
      ST_SG:    if (light_tick) state_d = ST_SY;
      ST_SY:    if (light_tick) state_d = ST_AR2;
      ST_AR2:   if (light_tick) state_d = flash_s ? ST_FLASH : (ped_pending ? ST_PED : ST_MG);
      ST_PED:   if (light_tick) state_d = flash_s ? ST_FLASH : ST_MG;
      ST_FLASH: if (sec_tick && !flash_s) state_d = ST_INIT;
      default:  state_d = ST_INIT;
    endcase
  end

  assign ctr_load   = (state_q == ST_INIT) | light_tick;
  assign load_count = pCount_width'(dur_m1(state_d, CFG));

  // Entering PED clears the request even if the button is still held on that edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ped_pending <= 1'b0;
      flash_tgl   <= 1'b0;
    end else begin
      if (state_q != ST_PED && state_d == ST_PED) ped_pending <= 1'b0;
      else if (ped_s && state_q != ST_PED)        ped_pending <= 1'b1;
      if (state_q == ST_FLASH && sec_tick)        flash_tgl   <= ~flash_tgl;
    end
  end

  always_comb begin
    lamps = '0;
    case (state_q)
      ST_MG: begin
        lamps[LAMP_MAIN_G] = 1'b1;
        lamps[LAMP_SIDE_R] = 1'b1;
      end
      ST_MY: begin
        lamps[LAMP_MAIN_Y] = 1'b1;
        lamps[LAMP_SIDE_R] = 1'b1;
      end
      ST_SG: begin
        lamps[LAMP_SIDE_G] = 1'b1;
        lamps[LAMP_MAIN_R] = 1'b1;
      end
      ST_SY: begin
        lamps[LAMP_SIDE_Y] = 1'b1;
        lamps[LAMP_MAIN_R] = 1'b1;
      end
      ST_PED: begin
        lamps[LAMP_MAIN_R] = 1'b1;
        lamps[LAMP_SIDE_R] = 1'b1;
        lamps[LAMP_WALK]   = 1'b1;
      end
      ST_FLASH: begin
        lamps[LAMP_MAIN_Y] = flash_tgl;
        lamps[LAMP_SIDE_R] = flash_tgl;
      end
      default: begin
        lamps[LAMP_MAIN_R] = 1'b1;
        lamps[LAMP_SIDE_R] = 1'b1;
      end
    endcase
  end

  assign main_r = lamps[LAMP_MAIN_R];
  assign main_y = lamps[LAMP_MAIN_Y];
  assign main_g = lamps[LAMP_MAIN_G];
  assign side_r = lamps[LAMP_SIDE_R];
  assign side_y = lamps[LAMP_SIDE_Y];
  assign side_g = lamps[LAMP_SIDE_G];
  assign walk   = lamps[LAMP_WALK];
  assign phase  = state_q;

endmodule

// File: tb/tb_light_phase_ctrl.sv
// Directed bench for light_phase_ctrl with a behavioural phase counter in the loop.
module tb_light_phase_ctrl;

  localparam logic [3:0] S_INIT  = 4'd0;
  localparam logic [3:0] S_MG    = 4'd1;
  localparam logic [3:0] S_MY    = 4'd2;
  localparam logic [3:0] S_AR1   = 4'd3;
  localparam logic [3:0] S_SG    = 4'd4;
  localparam logic [3:0] S_SY    = 4'd5;
  localparam logic [3:0] S_AR2   = 4'd6;
  localparam logic [3:0] S_PED   = 4'd7;
  localparam logic [3:0] S_FLASH = 4'd8;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       sec_tick = 1'b0;
  logic       light_tick;
  logic       flash_mode = 1'b0;
  logic       ped_req = 1'b0;
  logic       ctr_load;
  logic [4:0] load_count;
  logic       main_r, main_y, main_g, side_r, side_y, side_g, walk;
  logic [3:0] phase;
  logic [6:0] lamps;
  logic [4:0] cnt;
  logic       tgl = 1'b0;
  int         div = 0;
  int         checks = 0;
  int         failures = 0;

  light_phase_ctrl dut (
    .clk(clk), .rstb(rstb), .sec_tick(sec_tick), .light_tick(light_tick),
    .flash_mode(flash_mode), .ped_req(ped_req), .ctr_load(ctr_load),
    .load_count(load_count), .main_r(main_r), .main_y(main_y), .main_g(main_g),
    .side_r(side_r), .side_y(side_y), .side_g(side_g), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // One-clk second pulse every 4 clk, changed on the falling edge.
  always @(negedge clk) begin
    div = (div == 3) ? 0 : div + 1;
    sec_tick = (div == 0);
  end

  // Phase counter: loads on ctr_load, otherwise counts down per second.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)         cnt <= '0;
    else if (ctr_load) cnt <= load_count;
    else if (sec_tick) cnt <= cnt - 5'd1;
  end
  assign light_tick = (cnt == 5'd0) && sec_tick;

  assign lamps = {main_r, main_y, main_g, side_r, side_y, side_g, walk};

  function automatic logic [6:0] exp_lamps(input logic [3:0] s);
    case (s)
      S_MG:    return 7'b0011000;
      S_MY:    return 7'b0101000;
      S_SG:    return 7'b1000010;
      S_SY:    return 7'b1000100;
      S_PED:   return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 right after entering exp_st; runs until the phase changes.
  task automatic phase_run(input logic [3:0] exp_st, input int exp_secs,
                           input logic [3:0] exp_nx, input int exp_lc);
    int         n;
    logic       done, cl, st;
    logic [4:0] lc;
    chk($sformatf("phase_start_%0d", exp_st), 32'(phase), 32'(exp_st));
    chk($sformatf("lamps_%0d", exp_st), 32'(lamps), 32'(exp_lamps(exp_st)));
    n = 0; done = 1'b0; cl = 1'b0; lc = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      cl = ctr_load; lc = load_count; st = sec_tick;
      @(posedge clk); #1;
      if (st) n++;
      if (phase !== exp_st) begin
        done = 1'b1;
        break;
      end
    end
    chk($sformatf("phase_ends_%0d", exp_st), 32'(done), 32'd1);
    chk($sformatf("duration_%0d", exp_st), 32'(n), 32'(exp_secs));
    chk($sformatf("next_after_%0d", exp_st), 32'(phase), 32'(exp_nx));
    chk($sformatf("ctr_load_at_%0d", exp_st), 32'(cl), 32'd1);
    chk($sformatf("load_count_at_%0d", exp_st), 32'(lc), 32'(exp_lc));
  endtask

  task automatic main_cycle(input logic ped_in_sg, input int pend_mg,
                            input logic [3:0] ar2_nx, input int ar2_lc);
    phase_run(S_MG, 15, S_MY, 2);
    if (pend_mg >= 0) chk("ped_pending_after_mg", 32'(dut.ped_pending), 32'(pend_mg));
    phase_run(S_MY, 3, S_AR1, 1);
    phase_run(S_AR1, 2, S_SG, 9);
    if (ped_in_sg) fork
      begin
        repeat (8) @(negedge clk);
        ped_req = 1'b1;
        repeat (3) @(negedge clk);
        ped_req = 1'b0;
      end
    join_none
    phase_run(S_SG, 10, S_SY, 2);
    phase_run(S_SY, 3, S_AR2, 1);
    phase_run(S_AR2, 2, ar2_nx, ar2_lc);
  endtask

  // Checks the flashing pattern for secs seconds, then drops flash_mode and waits for INIT.
  task automatic flash_run(input int secs);
    logic got, done;
    for (int k = 0; k < secs; k++) begin
      chk("flash_phase", 32'(phase), 32'(S_FLASH));
      chk("flash_lamps", 32'(lamps), 32'({1'b0, tgl, 1'b0, tgl, 3'b000}));
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (sec_tick) begin
          got = 1'b1;
          break;
        end
      end
      chk("flash_tick_seen", 32'(got), 32'd1);
      tgl = ~tgl;
    end
    flash_mode = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sec_tick) tgl = ~tgl;
      if (phase !== S_FLASH) begin
        done = 1'b1;
        break;
      end
    end
    chk("flash_exit", 32'(done), 32'd1);
    chk("flash_exit_phase", 32'(phase), 32'(S_INIT));
    chk("flash_exit_lamps", 32'(lamps), 32'(7'b1001000));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 32'(S_INIT));
    chk("rst_lamps", 32'(lamps), 32'(7'b1001000));
    chk("rst_ctr_load", 32'(ctr_load), 32'd1);
    chk("rst_load_count", 32'(load_count), 32'd14);
    rstb = 1'b1;

    // Plain cycle, no requests
    phase_run(S_INIT, 1, S_MG, 14);
    main_cycle(1'b0, -1, S_MG, 14);

    // Pedestrian pulse during SG
    main_cycle(1'b1, -1, S_PED, 7);
    chk("ped_clr_on_entry", 32'(dut.ped_pending), 32'd0);
    phase_run(S_PED, 8, S_MG, 14);

    // Button held through PED: re-arms only after leaving PED
    ped_req = 1'b1;
    main_cycle(1'b0, -1, S_PED, 7);
    chk("ped_clr_while_held", 32'(dut.ped_pending), 32'd0);
    phase_run(S_PED, 8, S_MG, 14);
    fork
      begin
        repeat (3) @(negedge clk);
        ped_req = 1'b0;
      end
    join_none
    main_cycle(1'b0, 1, S_PED, 7);
    phase_run(S_PED, 8, S_MG, 14);

    // Flash raised in MG is taken only at AR2 expiry
    flash_mode = 1'b1;
    main_cycle(1'b0, -1, S_FLASH, 14);
    flash_run(3);
    phase_run(S_INIT, 1, S_MG, 14);

    // Flash beats a pending pedestrian request, which survives the flash
    flash_mode = 1'b1;
    fork
      begin
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        repeat (3) @(negedge clk);
        ped_req = 1'b0;
      end
    join_none
    main_cycle(1'b0, -1, S_FLASH, 14);
    chk("ped_held_in_flash", 32'(dut.ped_pending), 32'd1);
    flash_run(2);
    phase_run(S_INIT, 1, S_MG, 14);
    main_cycle(1'b0, -1, S_PED, 7);
    phase_run(S_PED, 8, S_MG, 14);

    // Reset mid-SG
    phase_run(S_MG, 15, S_MY, 2);
    phase_run(S_MY, 3, S_AR1, 1);
    phase_run(S_AR1, 2, S_SG, 9);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_lamps_sg", 32'(lamps), 32'(7'b1000010));
    rstb = 1'b0;
    #1;
    chk("midrst_phase", 32'(phase), 32'(S_INIT));
    chk("midrst_lamps", 32'(lamps), 32'(7'b1001000));
    chk("midrst_ctr_load", 32'(ctr_load), 32'd1);
    chk("midrst_load_count", 32'(load_count), 32'd14);
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    phase_run(S_INIT, 1, S_MG, 14);
    phase_run(S_MG, 15, S_MY, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
